// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants and coordinate widths shared by the
// raster generator and its consumers.
package vga_timing_pkg;

    localparam int CNT_W = 10;   // internal hCount/vCount width
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    localparam int DEF_WIDTH         = 640;
    localparam int DEF_H_FRONT_PORCH = 16;
    localparam int DEF_H_SYNC        = 96;
    localparam int DEF_H_BACK_PORCH  = 48;

    localparam int DEF_HEIGHT        = 480;
    localparam int DEF_V_FRONT_PORCH = 10;
    localparam int DEF_V_SYNC        = 2;
    localparam int DEF_V_BACK_PORCH  = 33;

    localparam int DEF_H_TOTAL = DEF_WIDTH + DEF_H_FRONT_PORCH + DEF_H_SYNC + DEF_H_BACK_PORCH;
    localparam int DEF_V_TOTAL = DEF_HEIGHT + DEF_V_FRONT_PORCH + DEF_V_SYNC + DEF_V_BACK_PORCH;

    // Half-open window test [lo, hi) on a counter value.
    function automatic logic in_window(input int c, input int lo, input int hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-MODULUS up-counter with enable, async active-high reset and a
// terminal-count flag that is high while the count sits at MODULUS-1.
module wrap_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("wrap_counter: MODULUS must lie in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_last;

    assign at_last = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = at_last ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: chained h/v wrap counters with purely combinational decode
// of syncs, active video, coordinates and end-of-frame strobe.
// Optional frameCount output when VGA_FRAME_COUNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int HEIGHT        = DEF_HEIGHT,
    parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int H_SYNC        = DEF_H_SYNC,
    parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
    parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
    parameter int V_SYNC        = DEF_V_SYNC,
    parameter int V_BACK_PORCH  = DEF_V_BACK_PORCH
) (
    input  logic           clk25,
    input  logic           reset,
    output logic           screenEnd,
    output logic           active,
    output logic           hSync,
    output logic           vSync,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]    frameCount
`endif
);

    localparam int H_TOTAL  = WIDTH + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL  = HEIGHT + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int HS_START = WIDTH + H_FRONT_PORCH;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = HEIGHT + V_FRONT_PORCH;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_timing
        $error("vga_timing_gen: timing totals do not fit the counter width");
    end

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_tc;
    // Vertical wrap is implied by the counter itself; nothing downstream needs it.
    logic             v_tc_unused;

    wrap_counter #(.WIDTH(CNT_W), .MODULUS(H_TOTAL)) u_hcnt (
        .clk_i   (clk25),
        .rst_i   (reset),
        .en_i    (1'b1),
        .count_o (h_cnt),
        .tc_o    (h_tc)
    );

    wrap_counter #(.WIDTH(CNT_W), .MODULUS(V_TOTAL)) u_vcnt (
        .clk_i   (clk25),
        .rst_i   (reset),
        .en_i    (h_tc),
        .count_o (v_cnt),
        .tc_o    (v_tc_unused)
    );

    int h_i, v_i;
    assign h_i = int'(h_cnt);
    assign v_i = int'(v_cnt);

    assign active    = (h_i < WIDTH) && (v_i < HEIGHT);
    assign hSync     = ~in_window(h_i, HS_START, HS_END);
    assign vSync     = ~in_window(v_i, VS_START, VS_END);
    assign screenEnd = (h_i == 0) && (v_i == HEIGHT);
    assign x         = h_cnt;
    assign y         = v_cnt[Y_W-1:0];

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (screenEnd) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frameCount = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance for line checks and a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int SW = 40, SHFP = 4, SHS = 8, SHBP = 6;
    localparam int SH = 30, SVFP = 3, SVS = 2, SVBP = 5;
    localparam int SHT = SW + SHFP + SHS + SHBP;   // 58
    localparam int SVT = SH + SVFP + SVS + SVBP;   // 40
    localparam int SFRAME = SHT * SVT;             // 2320
    localparam int DHT = 800, DVT = 525;

    logic       clk25 = 1'b0;
    logic       reset = 1'b0;
    logic       d_se, d_act, d_hs, d_vs, s_se, s_act, s_hs, s_vs;
    logic [9:0] d_x, s_x;
    logic [8:0] d_y, s_y;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    always #5 clk25 = ~clk25;

    vga_timing_gen dut_def (
        .clk25(clk25), .reset(reset), .screenEnd(d_se), .active(d_act),
        .hSync(d_hs), .vSync(d_vs), .x(d_x), .y(d_y)
`ifdef VGA_FRAME_COUNT_EN
        , .frameCount(d_fc)
`endif
    );

    vga_timing_gen #(
        .WIDTH(SW), .HEIGHT(SH), .H_FRONT_PORCH(SHFP), .H_SYNC(SHS),
        .H_BACK_PORCH(SHBP), .V_FRONT_PORCH(SVFP), .V_SYNC(SVS), .V_BACK_PORCH(SVBP)
    ) dut_sm (
        .clk25(clk25), .reset(reset), .screenEnd(s_se), .active(s_act),
        .hSync(s_hs), .vSync(s_vs), .x(s_x), .y(s_y)
`ifdef VGA_FRAME_COUNT_EN
        , .frameCount(s_fc)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;   // pixel clocks since reset release

    int   d_hs_cnt, s_act_cnt, s_vs_cnt, s_next_se;
    logic d_hs_prev, d_act_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s t=%0d: got %0d expected %0d", tag, t, obs, exp);
    endtask

    // Reference: raster position is just elapsed clocks folded by line/frame length.
    task automatic model(input int ht, input int vt, input int w, input int h,
                         input int hfp, input int hsw, input int vfp, input int vsw,
                         output int ex, output int ey, output int ea,
                         output int ehs, output int evs, output int ese);
        int hc, vc;
        hc  = t % ht;
        vc  = (t / ht) % vt;
        ex  = hc;
        ey  = vc % 512;
        ea  = (hc < w && vc < h) ? 1 : 0;
        ehs = (hc >= w + hfp && hc < w + hfp + hsw) ? 0 : 1;
        evs = (vc >= h + vfp && vc < h + vfp + vsw) ? 0 : 1;
        ese = (hc == 0 && vc == h) ? 1 : 0;
    endtask

`ifdef VGA_FRAME_COUNT_EN
    function automatic int exp_frames(input int ht, input int vt, input int h);
        if (t < h * ht) return 0;
        return ((t - h * ht) / (ht * vt) + 1) % 65536;
    endfunction
`endif

    task automatic check_outputs();
        int ex, ey, ea, ehs, evs, ese;
        model(DHT, DVT, 640, 480, 16, 96, 10, 2, ex, ey, ea, ehs, evs, ese);
        chk("def_x", 32'(d_x), 32'(ex));
        chk("def_y", 32'(d_y), 32'(ey));
        chk("def_active", 32'(d_act), 32'(ea));
        chk("def_hSync", 32'(d_hs), 32'(ehs));
        chk("def_vSync", 32'(d_vs), 32'(evs));
        chk("def_screenEnd", 32'(d_se), 32'(ese));
        model(SHT, SVT, SW, SH, SHFP, SHS, SVFP, SVS, ex, ey, ea, ehs, evs, ese);
        chk("sm_x", 32'(s_x), 32'(ex));
        chk("sm_y", 32'(s_y), 32'(ey));
        chk("sm_active", 32'(s_act), 32'(ea));
        chk("sm_hSync", 32'(s_hs), 32'(ehs));
        chk("sm_vSync", 32'(s_vs), 32'(evs));
        chk("sm_screenEnd", 32'(s_se), 32'(ese));
`ifdef VGA_FRAME_COUNT_EN
        chk("def_frameCount", 32'(d_fc), 32'(exp_frames(DHT, DVT, 480)));
        chk("sm_frameCount", 32'(s_fc), 32'(exp_frames(SHT, SVT, SH)));
`endif
    endtask

    // Interval measurements: pulse widths, edges and per-frame totals.
    task automatic measure();
        if (d_hs === 1'b0) d_hs_cnt++;
        if (d_hs === 1'b0 && d_hs_prev === 1'b1) chk("def_hsync_start", 32'(t % DHT), 32'd656);
        if (d_act === 1'b0 && d_act_prev === 1'b1 && (t / DHT) < 480)
            chk("def_active_fall", 32'(t % DHT), 32'd640);
        if (t % DHT == DHT - 1) begin
            chk("def_hsync_width", 32'(d_hs_cnt), 32'd96);
            d_hs_cnt = 0;
        end
        d_hs_prev  = d_hs;
        d_act_prev = d_act;

        if (s_act === 1'b1) s_act_cnt++;
        if (s_vs === 1'b0) s_vs_cnt++;
        if (s_se === 1'b1) begin
            chk("sm_screenEnd_time", 32'(t), 32'(s_next_se));
            s_next_se += SFRAME;
        end
        if (t % SFRAME == SFRAME - 1) begin
            chk("sm_active_per_frame", 32'(s_act_cnt), 32'(SW * SH));
            chk("sm_vsync_cycles", 32'(s_vs_cnt), 32'(SVS * SHT));
            s_act_cnt = 0;
            s_vs_cnt  = 0;
        end
    endtask

    task automatic release_reset();
        @(negedge clk25);
        reset      = 1'b0;
        t          = 0;
        d_hs_cnt   = 0;
        s_act_cnt  = 0;
        s_vs_cnt   = 0;
        s_next_se  = SH * SHT;
        d_hs_prev  = 1'b1;
        d_act_prev = 1'b1;
        check_outputs();
        measure();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk25);
            #1;
            t++;
            check_outputs();
            measure();
        end
    endtask

    // Async reset between edges must clear the raster before the next edge.
    task automatic mid_reset();
        @(posedge clk25);
        #3;
        reset = 1'b1;
        t     = 0;
        #1;
        check_outputs();
        repeat (2) @(posedge clk25);
        #1;
        check_outputs();
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 t = 0;
        check_outputs();

        release_reset();
        run(3 * DHT + int'($urandom_range(0, 300)));

        mid_reset();
        release_reset();
        run(3 * SFRAME + 100 + int'($urandom_range(0, 200)));
`ifdef VGA_FRAME_COUNT_EN
        chk("sm_frameCount_after3", 32'(s_fc), 32'd3);
`endif

        run(int'($urandom_range(50, 700)));
        mid_reset();
        release_reset();
        run(int'($urandom_range(200, 800)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates standard VGA raster timing from a 25 MHz pixel clock: horizontal/vertical counters, sync pulses, active-video flag, pixel coordinates and a one-cycle end-of-frame strobe.
- Sits in the VGA display path; its coordinates address the image RAM, paddle/ball hit tests and the frame-rate game update.

Parameters:
- WIDTH, 640, visible pixels per line
- HEIGHT, 480, visible lines per frame
- H_FRONT_PORCH, 16, pixel clocks after visible line
- H_SYNC, 96, hSync pulse width (pixel clocks)
- H_BACK_PORCH, 48, pixel clocks before next line
- V_FRONT_PORCH, 10, lines after visible frame
- V_SYNC, 2, vSync pulse width (lines)
- V_BACK_PORCH, 33, lines before next frame

Ports:
- clk25  input  1  pixel clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- screenEnd  output  1  high for one clk25 cycle at start of vertical blanking
- active  output  1  high while (hCount, vCount) is inside the visible region
- hSync  output  1  horizontal sync, active low
- vSync  output  1  vertical sync, active low
- x  output  10  horizontal pixel coordinate (hCount)
- y  output  9  vertical coordinate (vCount[8:0])

Behaviour:
- H_TOTAL = WIDTH+H_FRONT_PORCH+H_SYNC+H_BACK_PORCH (800 default). V_TOTAL = HEIGHT+V_FRONT_PORCH+V_SYNC+V_BACK_PORCH (525 default).
- Internal hCount and vCount are each 10 bits.
- Each clk25: hCount increments. At hCount==H_TOTAL-1, hCount wraps to 0 and vCount increments. vCount wraps to 0 when it is V_TOTAL-1 and hCount wraps.
- Reset: hCount=vCount=0 immediately (asynchronous). Outputs then read x=0, y=0, active=1, hSync=1, vSync=1, screenEnd=0.
- All outputs decode combinationally from the counter registers. There is zero latency between a counter value and its decoded outputs. No output registers.
- active = (hCount < WIDTH) && (vCount < HEIGHT).
- hSync = 0 iff WIDTH+H_FRONT_PORCH <= hCount < WIDTH+H_FRONT_PORCH+H_SYNC (656..751 default).
- vSync = 0 iff HEIGHT+V_FRONT_PORCH <= vCount < HEIGHT+V_FRONT_PORCH+V_SYNC (490..491 default). vSync spans whole lines.
- screenEnd = (hCount==0) && (vCount==HEIGHT). It is exactly one cycle per frame.
- x = hCount (0..799). y = vCount truncated to 9 bits; it aliases only during lines 512..524, which are blanking lines. Consumers qualify x/y with active.
- Reset asserted mid-frame restarts the raster at (0,0). No screenEnd pulse is generated by reset.
- Parameter sums must fit 10 bits; elaboration fails (assertion) otherwise.

Optional Feature:
- Macro VGA_FRAME_COUNT_EN.
- When defined: adds output frameCount [15:0]. Reset value is 0. It increments on each cycle where screenEnd=1 and wraps at 65535->0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds default timing constants (640/16/96/48, 480/10/2/33), the derived H_TOTAL/V_TOTAL, and the coordinate widths (10, 9).
- One sub-module, wrap_counter: parameterized modulus, increment enable, async reset and terminal-count output. It is instantiated for the horizontal counter (enable=1) and the vertical counter (enable=horizontal terminal count).

Test Plan:
- Reset: assert reset mid-line -> x=0, y=0, active=1, hSync=1, vSync=1, screenEnd=0 before the next clk25 edge.
- Line timing: from reset release, count cycles:
  - active drops at hCount=640.
  - hSync is low for exactly 96 cycles, starting at x=656.
  - The line period is 800 cycles, after which x returns to 0 and y increments by 1.
- Frame timing: screenEnd pulses for one cycle exactly 384000 cycles after reset release (x=0, y=480), then every 420000 cycles.
- vSync: low for exactly 1600 cycles (lines 490-491). It is never low during visible lines.
- Coverage: active is high exactly 307200 cycles per frame. y wraps to 0 after line 524 with x=0.
- With VGA_FRAME_COUNT_EN: frameCount reads 3 after 3 screenEnd pulses, and returns to 0 on reset.
